// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seg7_pkg;

  localparam int         SEG7_MAX_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK       = 7'h7F;
  localparam logic [6:0] SEG_ZERO        = 7'h40;

  // Hex nibble to active-low segment pattern for a common-anode digit.
  function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h18;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h27;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // The digit bank supports between one and eight digits.
  function automatic bit seg7_digits_legal(input int digits);
    return (digits >= 1) && (digits <= SEG7_MAX_DIGITS);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder (active-low segments).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Pure table lookup; no state.
  assign seg_o = seg7_encode(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-aligned double
// buffering. Loads land in a shadow register and are committed to the
// displayed value only at a frame boundary, so a scan never tears.
// Optional build macro: SEG7_LZ_BLANK_EN enables leading-zero suppression
// (digit 0 is never suppressed; suppression ORs with blank_mask).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [DIGITS-1:0]     scan,
  output logic [6:0]            HEX,
  output logic                  frame,
  output logic                  pending
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  generate
    if (!seg7_digits_legal(DIGITS)) begin : g_bad_digits
      $error("seg7_scan_driver: DIGITS must be in 1..8");
    end
    if (SCAN_DIV < 1) begin : g_bad_div
      $error("seg7_scan_driver: SCAN_DIV must be at least 1");
    end
  endgenerate

  logic [CW-1:0]         count_q, count_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic                  pending_q, pending_d;
  logic                  frame_q, frame_d;
  logic [DIGITS-1:0]     scan_q, scan_d;
  logic [6:0]            hex_q, hex_d;

  logic                  tick;
  logic                  boundary;
  logic [DIGITS-1:0]     idx_onehot;
  logic [DIGITS-1:0]     lz_blank;
  logic                  blank_hit;
  logic [3:0]            sel_nib;
  logic [6:0]            sel_seg;

  assign tick     = (count_q == COUNT_LAST);
  assign boundary = tick && (idx_q == IDX_LAST);

  // One-hot select for the slot that starts on this edge.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_onehot
    assign idx_onehot[gi] = (idx_d == IW'(gi));
  end

`ifdef SEG7_LZ_BLANK_EN
  // Digit i>0 goes dark when it and every higher nibble are zero.
  assign lz_blank[0] = 1'b0;
  for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
    assign lz_blank[gi] = (disp_d[4*DIGITS-1:4*gi] == '0);
  end
`else
  assign lz_blank = '0;
`endif

  assign blank_hit = |((blank_mask | lz_blank) & idx_onehot);

  // Pick the nibble of the (possibly just committed) value for the new slot.
  always_comb begin
    sel_nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_onehot[i]) begin
        sel_nib = sel_nib | disp_d[4*i +: 4];
      end
    end
  end

  seg7_decode u_decode (
    .nibble_i (sel_nib),
    .seg_o    (sel_seg)
  );

  // Next-state: prescaler, digit index, shadow/commit, and slot outputs.
  always_comb begin
    count_d   = tick ? '0 : count_q + 1'b1;
    idx_d     = idx_q;
    shadow_d  = load ? value : shadow_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    frame_d   = boundary;
    scan_d    = scan_q;
    hex_d     = hex_q;

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // A load coincident with the boundary bypasses the shadow.
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        disp_d = value;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end

    // Outputs only change at slot edges, so blank_mask is effectively
    // sampled once per slot.
    if (tick) begin
      scan_d = idx_onehot;
      hex_d  = blank_hit ? SEG_BLANK : sel_seg;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      scan_q    <= DIGITS'(1);
      hex_q     <= SEG_ZERO;
    end else begin
      count_q   <= count_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
      scan_q    <= scan_d;
      hex_q     <= hex_d;
    end
  end

  assign scan    = scan_q;
  assign HEX     = hex_q;
  assign frame   = frame_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4) plus a DIGITS=1,
// SCAN_DIV=1 instance. A reference model pushes the expected outputs each
// clock; a monitor pops and compares them each falling edge. A vector table
// adds fixed expectations at chosen cycles.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit         LZ = 1'b1;
  localparam logic [6:0] ZH = 7'h7F;
`else
  localparam bit         LZ = 1'b0;
  localparam logic [6:0] ZH = 7'h40;
`endif

  typedef struct packed {
    logic [3:0] scan;
    logic [6:0] hex;
    logic       frame;
    logic       pend;
  } obs_t;

  typedef struct {
    int         cyc;
    logic       drv;
    logic       ld;
    logic [15:0] val;
    logic [3:0] blk;
    logic       chk;
    logic [3:0] scan;
    logic [6:0] hex;
    logic       frame;
    logic       pend;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  scan;
  logic [6:0]  HEX;
  logic        frame;
  logic        pending;

  logic        load1 = 1'b0;
  logic [3:0]  value1 = 4'h0;
  logic [0:0]  blank1 = 1'b0;
  logic [0:0]  scan1;
  logic [6:0]  hex1;
  logic        frame1;
  logic        pend1;

  int checks = 0;
  int errors = 0;

  obs_t exp_q[$];
  vec_t vecs[$];

  logic [6:0] enc_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_mask (blank_mask),
    .scan       (scan),
    .HEX        (HEX),
    .frame      (frame),
    .pending    (pending)
  );

  seg7_scan_driver #(.DIGITS(1), .SCAN_DIV(1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value1),
    .load       (load1),
    .blank_mask (blank1),
    .scan       (scan1),
    .HEX        (hex1),
    .frame      (frame1),
    .pending    (pend1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit lz_hide(input logic [15:0] d, input logic [1:0] i);
    return LZ && (i != 2'd0) && ((d >> (4 * int'(i))) == 16'h0);
  endfunction

  task automatic add(input int cyc, input logic drv, input logic ld, input logic [15:0] val,
                     input logic [3:0] blk, input logic chk, input logic [3:0] sc,
                     input logic [6:0] hx, input logic fr, input logic pd);
    vec_t v;
    v.cyc = cyc; v.drv = drv; v.ld = ld; v.val = val; v.blk = blk;
    v.chk = chk; v.scan = sc; v.hex = hx; v.frame = fr; v.pend = pd;
    vecs.push_back(v);
  endtask

  // Reference model state (behaviour written from the display contract).
  int          m_count = 0;
  logic [1:0]  m_idx = 2'd0;
  logic [15:0] m_shadow = 16'h0;
  logic [15:0] m_disp = 16'h0;
  logic        m_pend = 1'b0;
  logic [3:0]  m_scan = 4'b0001;
  logic [6:0]  m_hex = 7'h40;

  // Model step: compute expected outputs after this edge and queue them.
  always @(posedge clk) begin : model
    obs_t        e;
    logic        tick;
    logic        bnd;
    logic [1:0]  nidx;
    logic [15:0] ndisp;
    logic        npend;
    logic [3:0]  nib;
    if (!rst_n) begin
      e = '{scan: 4'b0001, hex: 7'h40, frame: 1'b0, pend: 1'b0};
      m_count  <= 0;
      m_idx    <= 2'd0;
      m_shadow <= 16'h0;
      m_disp   <= 16'h0;
      m_pend   <= 1'b0;
      m_scan   <= 4'b0001;
      m_hex    <= 7'h40;
    end else begin
      tick  = (m_count == SCAN_DIV - 1);
      bnd   = tick && (m_idx == 2'd3);
      ndisp = m_disp;
      npend = m_pend;
      if (bnd) begin
        npend = 1'b0;
        if (load) ndisp = value;
        else if (m_pend) ndisp = m_shadow;
      end else if (load) begin
        npend = 1'b1;
      end
      nidx = tick ? ((m_idx == 2'd3) ? 2'd0 : m_idx + 2'd1) : m_idx;
      nib  = 4'(ndisp >> (4 * int'(nidx)));
      e.frame = bnd;
      e.pend  = npend;
      e.scan  = tick ? (4'b0001 << nidx) : m_scan;
      if (tick) e.hex = (blank_mask[nidx] || lz_hide(ndisp, nidx)) ? 7'h7F : enc_tab[nib];
      else      e.hex = m_hex;
      m_count  <= tick ? 0 : m_count + 1;
      m_idx    <= nidx;
      m_shadow <= load ? value : m_shadow;
      m_disp   <= ndisp;
      m_pend   <= npend;
      m_scan   <= e.scan;
      m_hex    <= e.hex;
    end
    exp_q.push_back(e);
  end

  // Monitor: compare DUT outputs against the queued expectation.
  always @(negedge clk) begin : monitor
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {scan, HEX, frame, pending};
      check("scoreboard", 32'(a), 32'(e));
    end
  end

  initial begin
    int vi;
    vi = 0;

    // cyc, drv, ld, val, blk, chk, scan, hex, frame, pend
    add(  1, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h40, 0, 0);
    add(  3, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h40, 0, 0);
    add(  4, 0, 0, 16'h0000, 4'h0, 1, 4'b0010, ZH,    0, 0);
    add( 15, 0, 0, 16'h0000, 4'h0, 1, 4'b1000, ZH,    0, 0);
    add( 16, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h40, 1, 0);
    add( 17, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h40, 0, 0);
    add( 20, 1, 1, 16'h12AF, 4'h0, 1, 4'b0010, ZH,    0, 0);
    add( 21, 0, 0, 16'h0000, 4'h0, 1, 4'b0010, ZH,    0, 1);
    add( 24, 0, 0, 16'h0000, 4'h0, 1, 4'b0100, ZH,    0, 1);
    add( 28, 0, 0, 16'h0000, 4'h0, 1, 4'b1000, ZH,    0, 1);
    add( 31, 0, 0, 16'h0000, 4'h0, 1, 4'b1000, ZH,    0, 1);
    add( 32, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h0E, 1, 0);
    add( 36, 0, 0, 16'h0000, 4'h0, 1, 4'b0010, 7'h08, 0, 0);
    add( 40, 0, 0, 16'h0000, 4'h0, 1, 4'b0100, 7'h24, 0, 0);
    add( 44, 0, 0, 16'h0000, 4'h0, 1, 4'b1000, 7'h79, 0, 0);
    add( 49, 1, 1, 16'h1111, 4'h0, 1, 4'b0001, 7'h0E, 0, 0);
    add( 50, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h0E, 0, 1);
    add( 53, 1, 1, 16'h2222, 4'h0, 1, 4'b0010, 7'h08, 0, 1);
    add( 56, 0, 0, 16'h0000, 4'h0, 1, 4'b0100, 7'h24, 0, 1);
    add( 64, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h24, 1, 0);
    add( 68, 0, 0, 16'h0000, 4'h0, 1, 4'b0010, 7'h24, 0, 0);
    add( 72, 0, 0, 16'h0000, 4'h0, 1, 4'b0100, 7'h24, 0, 0);
    add( 76, 0, 0, 16'h0000, 4'h0, 1, 4'b1000, 7'h24, 0, 0);
    add( 79, 1, 1, 16'h0007, 4'h0, 1, 4'b1000, 7'h24, 0, 0);
    add( 80, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h78, 1, 0);
    add( 81, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h78, 0, 0);
    add( 84, 0, 0, 16'h0000, 4'h0, 1, 4'b0010, ZH,    0, 0);
    add( 85, 1, 1, 16'h0000, 4'h0, 1, 4'b0010, ZH,    0, 0);
    add( 86, 0, 0, 16'h0000, 4'h0, 1, 4'b0010, ZH,    0, 1);
    add( 88, 0, 0, 16'h0000, 4'h0, 1, 4'b0100, ZH,    0, 1);
    add( 89, 1, 0, 16'h0000, 4'h4, 1, 4'b0100, ZH,    0, 1);
    add( 90, 0, 0, 16'h0000, 4'h0, 1, 4'b0100, ZH,    0, 1);
    add( 92, 0, 0, 16'h0000, 4'h0, 1, 4'b1000, ZH,    0, 1);
    add( 96, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h40, 1, 0);
    add(100, 0, 0, 16'h0000, 4'h0, 1, 4'b0010, ZH,    0, 0);
    add(104, 0, 0, 16'h0000, 4'h0, 1, 4'b0100, 7'h7F, 0, 0);
    add(108, 0, 0, 16'h0000, 4'h0, 1, 4'b1000, ZH,    0, 0);
    add(113, 1, 1, 16'h5A5A, 4'h0, 1, 4'b0001, 7'h40, 0, 0);
    add(114, 0, 0, 16'h0000, 4'h0, 1, 4'b0001, 7'h40, 0, 1);
    add(121, 0, 0, 16'h0000, 4'h0, 1, 4'b0100, ZH,    0, 1);

    // Reset held: outputs at reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset_scan",  32'(scan),    32'h1);
    check("reset_hex",   32'(HEX),     32'h40);
    check("reset_frame", 32'(frame),   32'h0);
    check("reset_pend",  32'(pending), 32'h0);
    check("reset_hex1",  32'(hex1),    32'h40);

    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int n = 1; n <= 121; n++) begin
      @(posedge clk);
      #1;
      load  = 1'b0;
      load1 = 1'b0;
      while (vi < vecs.size() && vecs[vi].cyc == n) begin
        if (vecs[vi].chk) begin
          check($sformatf("scan@%0d", n),  32'(scan),    32'(vecs[vi].scan));
          check($sformatf("hex@%0d", n),   32'(HEX),     32'(vecs[vi].hex));
          check($sformatf("frame@%0d", n), 32'(frame),   32'(vecs[vi].frame));
          check($sformatf("pend@%0d", n),  32'(pending), 32'(vecs[vi].pend));
        end
        if (vecs[vi].drv) begin
          load       = vecs[vi].ld;
          value      = vecs[vi].val;
          blank_mask = vecs[vi].blk;
        end
        vi++;
      end
      // Single-digit, divide-by-one instance: every cycle is a frame edge.
      if (n == 1) begin
        check("d1_scan",  32'(scan1),  32'h1);
        check("d1_frame", 32'(frame1), 32'h1);
      end
      if (n == 2) begin
        load1  = 1'b1;
        value1 = 4'h3;
      end
      if (n == 3) begin
        check("d1_hex",  32'(hex1),  32'h30);
        check("d1_pend", 32'(pend1), 32'h0);
      end
      if (n == 4) begin
        check("d1_frame2", 32'(frame1), 32'h1);
        check("d1_scan2",  32'(scan1),  32'h1);
      end
    end

    // Reset during the idx=2 slot with a pending value: immediate clear.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_scan",  32'(scan),    32'h1);
    check("arst_hex",   32'(HEX),     32'h40);
    check("arst_frame", 32'(frame),   32'h0);
    check("arst_pend",  32'(pending), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int n = 1; n <= 17; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        check("post_scan1", 32'(scan),    32'h1);
        check("post_hex1",  32'(HEX),     32'h40);
        check("post_pend1", 32'(pending), 32'h0);
      end
      if (n == 4) begin
        check("post_scan4", 32'(scan), 32'h2);
        check("post_hex4",  32'(HEX),  32'(ZH));
      end
      if (n == 16) begin
        check("post_frame16", 32'(frame),   32'h1);
        check("post_hex16",   32'(HEX),     32'h40);
        check("post_pend16",  32'(pending), 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits. It displays a DIGITS-nibble hex value by scanning one digit at a time: a one-hot digit-select output is paired with that digit's active-low segment pattern. Loaded values are double-buffered and committed only at frame boundaries, so the display never tears mid-scan. It sits between register/status logic (e.g. SDRAM test counters) and the board's shared segment and digit-select pins.

## Interface
- DIGITS, 4: number of digits scanned; legal range 1..8.
- SCAN_DIV, 50000: clock cycles per digit slot; minimum 1.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- value  input  4*DIGITS  hex value; nibble i drives digit i, and digit 0 is the least significant.
- load  input  1  single-cycle strobe that captures value into the shadow register.
- blank_mask  input  DIGITS  bit i=1 forces digit i dark; sampled live, not buffered.
- scan  output  DIGITS  one-hot digit select, active-high; registered.
- HEX  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit); registered.
- frame  output  1  one-cycle pulse on each frame-boundary edge.
- pending  output  1  high while the shadow holds a value not yet committed.

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick = (count == SCAN_DIV-1).
- Digit index idx counts 0..DIGITS-1 and advances on tick. It wraps from DIGITS-1 to 0.
- Frame boundary = tick while idx == DIGITS-1.
- load=1 writes value into shadow and sets pending. A second load before commit overwrites shadow and keeps pending set.
- At a frame boundary with pending=1: disp <= shadow and pending clears.
- At a frame boundary with load=1 in the same cycle: disp <= value directly and pending clears.
- Segment encoding for nibbles 0..F: 40,79,24,30,19,12,02,78,00,18,08,03,27,21,06,0E (hex, 7-bit). Blank = 7F.
- HEX is driven with blank when blank_mask[idx] is set. Otherwise it carries the encoding of disp nibble idx.

## Timing
- Reset values: count=0, idx=0, shadow=0, disp=0, pending=0, frame=0, scan=one-hot bit 0 (0…01), HEX=7'b1000000.
- scan and HEX update on the same edge where idx advances, and reflect the new idx. Each digit is shown for exactly SCAN_DIV cycles.
- frame asserts on the edge where idx wraps to 0.
- A committed value first appears in the digit-0 slot that starts on the frame edge.
- load-to-display latency: at most DIGITS*SCAN_DIV cycles plus 1.
- pending rises on the edge after load and falls on the commit edge.
- A change on blank_mask takes effect at the next digit-slot edge, not mid-slot.
- When SCAN_DIV=1, tick is constant. idx then advances every cycle, and every DIGITS-th cycle is a frame boundary.
- When DIGITS=1, every tick is a frame boundary and scan is constantly 1.
- Reset asserted mid-frame returns all state to reset values immediately. Uncommitted shadow data is lost.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero suppression is active.
  - A digit i>0 is blanked when disp nibble i and all higher nibbles are 0.
  - Digit 0 is never suppressed, so disp=0 shows a single "0".
  - Suppression ORs with blank_mask.
- SEG7_LZ_BLANK_EN undefined: all digits show their nibble, and only blank_mask blanks.

## Structure
- seg7_pkg holds:
  - the SEG_BLANK (7'h7F) constant;
  - the 16-entry segment encoding as a constant function seg7_encode(nibble);
  - the DIGITS legality check.
- Sub-module seg7_decode: a combinational nibble-to-segment decoder built on seg7_encode. The driver instantiates it once, on the selected nibble.
- The prescaler, index counter, shadow/disp registers and output registers live in seg7_scan_driver.

## Test plan
- Reset check, with DIGITS=4 and SCAN_DIV=4. Release rst_n.
  - Required: scan=0001 and HEX=40 for 4 cycles, then scan=0010.
  - Required: frame pulses every 16 cycles.
- Load mid-frame: load value=16'h12AF during the idx=1 slot.
  - Required: pending=1, and the display keeps showing 0 until the frame edge.
  - Required: afterwards the slots show F(0E), A(08), 2(24), 1(79), and pending=0.
- Double load: load 16'h1111, then 16'h2222 within the same frame.
  - Required: only 2222 is ever displayed.
- Load on boundary: load=1 coincident with the frame-boundary tick, value=16'h0007.
  - Required: digit 0 shows 78 in the immediately following slot, and pending stays 0.
- Blanking: set blank_mask=4'b0100 with disp=16'h0000.
  - Required: the idx=2 slot shows HEX=7F.
  - Required with SEG7_LZ_BLANK_EN: digits 1–3 show 7F and digit 0 shows 40.
- Reset mid-frame: assert rst_n=0 during the idx=2 slot while pending=1.
  - Required: all outputs return to their reset values asynchronously.
  - Required: after release the display shows 0.
